// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults and coordinate type for the VGA path.
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CW       = 10;
    typedef logic [VGA_CW-1:0] coord_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level, reset to 0.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            q    <= 1'b0;
        end else begin
            s1_q <= d;
            q    <= s1_q;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters and registered sync/enable/coordinate decode,
// started and stopped by the synchronised PLL lock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pll_lock,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          vblank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic          run;
    logic          h_wrap;
    logic [31:0]   hw, vw;
    logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          vblank_q, vblank_d, ls_q, ls_d, fs_q, fs_d;

    sync2 u_sync (.clk(clk), .reset(reset), .d(pll_lock), .q(run));

    // Every decode is gated by run so the edge that sees run fall already idles the outputs.
    always_comb begin
        hw       = 32'(h_q);
        vw       = 32'(v_q);
        h_wrap   = h_q == H_LAST;
        h_d      = (!run || h_wrap) ? '0 : h_q + CW'(1);
        v_d      = !run ? '0 : !h_wrap ? v_q : (v_q == V_LAST) ? '0 : v_q + CW'(1);
        hsync_d  = (run && hw >= HS_START && hw < HS_END) ? HS_POL : ~HS_POL;
        vsync_d  = (run && vw >= VS_START && vw < VS_END) ? VS_POL : ~VS_POL;
        de_d     = run && hw < H_ACTIVE && vw < V_ACTIVE;
        vblank_d = run && vw >= V_ACTIVE;
        x_d      = run ? h_q : '0;
        y_d      = run ? v_q : '0;
        ls_d     = run && h_q == '0;
        fs_d     = ls_d && v_q == '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            vblank_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            vblank_q <= vblank_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign vblank      = vblank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default, short-frame and tiny active-high rasters.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pll_lock = 1'b0;
    int checks = 0;
    int failures = 0;

    logic       d_hs, d_vs, d_de, d_vb, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       m_hs, m_vs, m_de, m_vb, m_ls, m_fs;
    logic [9:0] m_x, m_y;
    logic       s_hs, s_vs, s_de, s_vb, s_ls, s_fs;
    logic [3:0] s_x, s_y;

    always #5 clk = ~clk;

    vga_timing_gen u_d (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .vblank(d_vb), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_m (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(m_hs), .vsync(m_vs), .de(m_de),
        .vblank(m_vb), .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs)
    );

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)) u_s (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .vblank(s_vb), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, ls_next = -1;
        int vs_cnt = 0, vs_fx = -1, vs_fy = -1, vb_cnt = 0, fs_next = -1;
        step(3);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_de", d_de, 0);
        chk("rst_vb", d_vb, 0);
        chk("rst_xy", {d_x, d_y}, 0);
        chk("rst_fs_ls", {d_fs, d_ls}, 0);
        chk("rst_s_syncs", {s_hs, s_vs}, 0);
        reset = 1'b0;
        step(2);
        chk("nolock_idle", {d_fs, d_ls, d_de, d_x}, 0);
        pll_lock = 1'b1;
        step(2);
        chk("lock_k1_fs", d_fs, 0);
        step(1);
        chk("lock_fs", d_fs, 1);
        chk("lock_ls", d_ls, 1);
        chk("lock_xy", {d_x, d_y}, 0);
        chk("lock_hs", d_hs, 1);
        chk("lock_s_fs", s_fs, 1);
        for (int n = 0; n <= 8800; n++) begin
            if (n > 0) step(1);
            if (n < 800) begin
                de_cnt += int'(d_de);
                if (!d_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(d_x);
                end
            end
            if (n > 0 && d_ls && ls_next < 0) ls_next = n;
            if (!m_vs) begin
                vs_cnt++;
                if (vs_fx < 0) begin
                    vs_fx = int'(m_x);
                    vs_fy = int'(m_y);
                end
            end
            vb_cnt += int'(m_vb);
            if (n > 0 && m_fs && fs_next < 0) fs_next = n;
            case (n)
                1:  chk("d_x_inc", d_x, 1);
                7:  chk("s_de_x7", s_de, 1);
                8:  chk("s_de_x8", s_de, 0);
                9:  chk("s_hs_x9", s_hs, 0);
                10: chk("s_hs_x10", s_hs, 1);
                11: chk("s_hs_x11", s_hs, 1);
                12: chk("s_hs_x12", s_hs, 0);
                13: chk("s_x13", s_x, 13);
                14: chk("s_wrap", {s_x, s_y, 3'(s_ls)}, {4'd0, 4'd1, 3'd1});
                55: chk("s_vb_y3", s_vb, 0);
                56: chk("s_vb_y4", s_vb, 1);
                69: chk("s_vs_y4", s_vs, 0);
                70: chk("s_vs_y5", s_vs, 1);
                84: chk("s_vs_y6", {s_vs, s_y}, {1'b0, 4'd6});
                98: chk("s_frame", {s_fs, s_x, s_y}, {1'b1, 8'd0});
                default: ;
            endcase
        end
        chk("d_de_cnt", de_cnt, 640);
        chk("d_hs_cnt", hs_cnt, 96);
        chk("d_hs_first", hs_first, 656);
        chk("d_ls_period", ls_next, 800);
        chk("m_vs_cnt", vs_cnt, 1600);
        chk("m_vs_first_x", vs_fx, 0);
        chk("m_vs_first_y", vs_fy, 6);
        chk("m_vb_cnt", vb_cnt, 5600);
        chk("m_frame_period", fs_next, 8800);
        step(16300 - 8800);
        chk("pre_drop_x", d_x, 300);
        chk("pre_drop_y", d_y, 20);
        pll_lock = 1'b0;
        step(2);
        chk("drop_k1_x", d_x, 302);
        step(1);
        chk("drop_idle_xy", {d_x, d_y}, 0);
        chk("drop_idle_de_vb", {d_de, d_vb, d_fs, d_ls}, 0);
        chk("drop_idle_syncs", {d_hs, d_vs, s_hs, s_vs}, 4'b1100);
        chk("drop_idle_m", {m_x, m_y}, 0);
        pll_lock = 1'b1;
        step(3);
        chk("relock_fs_ls", {d_fs, d_ls}, 2'b11);
        chk("relock_xy", {d_x, d_y}, 0);
        step(1);
        chk("relock_x1", d_x, 1);
        step(699);
        chk("pre_rst_x", d_x, 700);
        chk("pre_rst_hs", d_hs, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_hs", d_hs, 1);
        chk("async_rst_de", d_de, 0);
        chk("async_rst_xy", {d_x, d_y}, 0);
        step(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
